// File: rtl/bexkat2_intunit_seq_pkg.sv
// Shared types for the multi-cycle integer unit: operation codes, FSM
// states, the fast-path latency constant and small decode helpers.
package bexkat2_intunit_seq_pkg;

  // Integer operation codes; 12-15 are unassigned and produce 0.
  typedef enum logic [3:0] {
    INT_MUL   = 4'd0,
    INT_DIV   = 4'd1,
    INT_MOD   = 4'd2,
    INT_MULU  = 4'd3,
    INT_DIVU  = 4'd4,
    INT_MODU  = 4'd5,
    INT_MULX  = 4'd6,
    INT_MULUX = 4'd7,
    INT_EXT   = 4'd8,
    INT_EXTB  = 4'd9,
    INT_COM   = 4'd10,
    INT_NEG   = 4'd11
  } intfunc_t;

  typedef enum logic [2:0] {
    IS_IDLE = 3'd0,
    IS_PREP = 3'd1,
    IS_ITER = 3'd2,
    IS_FIX  = 3'd3,
    IS_DONE = 3'd4
  } intstate_t;

  // Start-to-done latency of single-cycle (unary / unassigned) operations.
  localparam int INT_FAST_LAT = 1;

  // Multiply family (shift-add engine).
  function automatic logic is_mul_op(input logic [3:0] f);
    logic r;
    case (f)
      INT_MUL, INT_MULU, INT_MULX, INT_MULUX: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

  // Divide / modulo family (restoring-divide engine).
  function automatic logic is_div_op(input logic [3:0] f);
    logic r;
    case (f)
      INT_DIV, INT_DIVU, INT_MOD, INT_MODU: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

  // Operations whose operands are two's-complement signed.
  function automatic logic is_signed_op(input logic [3:0] f);
    logic r;
    case (f)
      INT_MUL, INT_MULX, INT_DIV, INT_MOD: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Operations that go through the iterative engine.
  function automatic logic is_long_op(input logic [3:0] f);
    return is_mul_op(f) | is_div_op(f);
  endfunction

endpackage

// File: rtl/bexkat2_intunit_seq_if.sv
// Request/response bundle between the control FSM (master) and the
// integer unit (slave).
interface bexkat2_intunit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       func_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] result_hi_o;
  logic             div0_o;

  modport master (
    output start_i, func_i, a_i, b_i,
    input  busy_o, done_o, result_o, result_hi_o, div0_o
  );

  modport slave (
    input  start_i, func_i, a_i, b_i,
    output busy_o, done_o, result_o, result_hi_o, div0_o
  );
endinterface

// File: rtl/bexkat2_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module bexkat2_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] diff_s;
  logic             fits_s;

  // Trial subtraction; the partial remainder stays below the divisor so the
  // low WIDTH bits of the difference are exact whenever it fits.
  always_comb begin
    shifted_s = {rem, quo[WIDTH-1]};
    diff_s    = shifted_s[WIDTH-1:0] - divisor;
    fits_s    = (shifted_s >= {1'b0, divisor});
    if (fits_s) begin
      rem_next = diff_s;
    end else begin
      rem_next = shifted_s[WIDTH-1:0];
    end
    quo_next = {quo[WIDTH-2:0], fits_s};
  end
endmodule

// File: rtl/bexkat2_intunit_seq.sv
// Multi-cycle integer unit. Unary operations finish in one cycle; multiply
// and divide families run WIDTH/BPC iteration cycles on operand magnitudes,
// then apply sign correction and divide-by-zero handling.
module bexkat2_intunit_seq
  import bexkat2_intunit_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  bexkat2_intunit_seq_if.slave bus
);

  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  intstate_t          state_r, state_nxt_s;
  logic               accept_s, long_s, busy_nxt_s;
  logic [3:0]         func_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               neg_a_r, neg_b_r;
  logic               signed_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH-1:0]   mcand_r, dvsr_r, rem_r, quo_r;
  logic [2*WIDTH-1:0] prod_r, prod_nxt_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [BPC:0][WIDTH-1:0] rem_chain_s;
  logic [BPC:0][WIDTH-1:0] quo_chain_s;
  logic [WIDTH-1:0]   unary_res_s;
  logic               neg_q_s, div0_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;
  logic [WIDTH-1:0]   fix_res_s, fix_hi_s;
  logic               fix_div0_s;
  logic [WIDTH-1:0]   result_r, result_hi_r;
  logic               div0_r, done_r, busy_r;

  assign accept_s = bus.start_i && ((state_r == IS_IDLE) || (state_r == IS_DONE));
  assign long_s   = is_long_op(bus.func_i);
  assign signed_s = is_signed_op(func_r);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IS_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; DONE accepts a new request exactly like IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IS_IDLE, IS_DONE: begin
        if (accept_s) begin
          if (long_s) begin
            state_nxt_s = IS_PREP;
          end else begin
            state_nxt_s = IS_DONE;
          end
        end else begin
          state_nxt_s = IS_IDLE;
        end
      end
      IS_PREP: state_nxt_s = IS_ITER;
      IS_ITER: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = IS_FIX;
        end else begin
          state_nxt_s = IS_ITER;
        end
      end
      IS_FIX:  state_nxt_s = IS_DONE;
      default: state_nxt_s = IS_IDLE;
    endcase
    busy_nxt_s = (state_nxt_s == IS_PREP) || (state_nxt_s == IS_ITER) ||
                 (state_nxt_s == IS_FIX);
  end

  // Operand magnitudes for signed operations (MIN maps to itself, which is
  // the correct unsigned magnitude).
  always_comb begin
    if (signed_s && a_r[WIDTH-1]) begin
      mag_a_s = {WIDTH{1'b0}} - a_r;
    end else begin
      mag_a_s = a_r;
    end
    if (signed_s && b_r[WIDTH-1]) begin
      mag_b_s = {WIDTH{1'b0}} - b_r;
    end else begin
      mag_b_s = b_r;
    end
  end

  // BPC shift-add multiply steps: {carry, high} += multiplicand when the
  // multiplier LSB is set, then the whole product register shifts right.
  always_comb begin
    prod_nxt_s = prod_r;
    mul_sum_s  = {(WIDTH+1){1'b0}};
    for (int i = 0; i < BPC; i++) begin
      if (prod_nxt_s[0]) begin
        mul_sum_s = {1'b0, prod_nxt_s[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
      end else begin
        mul_sum_s = {1'b0, prod_nxt_s[2*WIDTH-1:WIDTH]};
      end
      prod_nxt_s = {mul_sum_s, prod_nxt_s[WIDTH-1:1]};
    end
  end

  assign rem_chain_s[0] = rem_r;
  assign quo_chain_s[0] = quo_r;

  for (genvar g = 0; g < BPC; g++) begin : g_div
    bexkat2_divstep #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_chain_s[g]),
      .quo      (quo_chain_s[g]),
      .divisor  (dvsr_r),
      .rem_next (rem_chain_s[g+1]),
      .quo_next (quo_chain_s[g+1])
    );
  end

  // Operand capture, engine preparation and iteration.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      func_r  <= 4'd0;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      neg_a_r <= 1'b0;
      neg_b_r <= 1'b0;
      mcand_r <= {WIDTH{1'b0}};
      dvsr_r  <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      prod_r  <= {(2*WIDTH){1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IS_IDLE, IS_DONE: begin
          if (accept_s) begin
            func_r <= bus.func_i;
            a_r    <= bus.a_i;
            b_r    <= bus.b_i;
          end
        end
        IS_PREP: begin
          neg_a_r <= signed_s & a_r[WIDTH-1];
          neg_b_r <= signed_s & b_r[WIDTH-1];
          mcand_r <= mag_a_s;
          dvsr_r  <= mag_b_s;
          prod_r  <= {{WIDTH{1'b0}}, mag_b_s};
          rem_r   <= {WIDTH{1'b0}};
          quo_r   <= mag_a_s;
          cnt_r   <= CNT_W'(N - 1);
        end
        IS_ITER: begin
          prod_r <= prod_nxt_s;
          rem_r  <= rem_chain_s[BPC];
          quo_r  <= quo_chain_s[BPC];
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Single-cycle operations computed straight from the request operands.
  always_comb begin
    case (bus.func_i)
      INT_EXT:  unary_res_s = {{(WIDTH-16){bus.a_i[15]}}, bus.a_i[15:0]};
      INT_EXTB: unary_res_s = {{(WIDTH-8){bus.a_i[7]}}, bus.a_i[7:0]};
      INT_COM:  unary_res_s = ~bus.a_i;
      INT_NEG:  unary_res_s = {WIDTH{1'b0}} - bus.a_i;
      default:  unary_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Sign correction and divide-by-zero results for the iterative families.
  always_comb begin
    fix_res_s  = {WIDTH{1'b0}};
    fix_hi_s   = {WIDTH{1'b0}};
    fix_div0_s = 1'b0;
    div0_s     = (b_r == {WIDTH{1'b0}});
    neg_q_s    = neg_a_r ^ neg_b_r;
    if (neg_q_s) begin
      prod_fix_s = {(2*WIDTH){1'b0}} - prod_r;
      quo_fix_s  = {WIDTH{1'b0}} - quo_r;
    end else begin
      prod_fix_s = prod_r;
      quo_fix_s  = quo_r;
    end
    if (neg_a_r) begin
      rem_fix_s = {WIDTH{1'b0}} - rem_r;
    end else begin
      rem_fix_s = rem_r;
    end
    case (func_r)
      INT_MUL, INT_MULU, INT_MULX, INT_MULUX: begin
        fix_res_s = prod_fix_s[WIDTH-1:0];
        fix_hi_s  = prod_fix_s[2*WIDTH-1:WIDTH];
      end
      INT_DIV, INT_DIVU: begin
        fix_res_s  = div0_s ? {WIDTH{1'b1}} : quo_fix_s;
        fix_div0_s = div0_s;
      end
      INT_MOD, INT_MODU: begin
        fix_res_s  = div0_s ? a_r : rem_fix_s;
        fix_div0_s = div0_s;
      end
      default: begin
        fix_res_s  = {WIDTH{1'b0}};
        fix_hi_s   = {WIDTH{1'b0}};
        fix_div0_s = 1'b0;
      end
    endcase
  end

  // Registered outputs; results hold until the next operation completes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      div0_r      <= 1'b0;
    end else begin
      done_r <= (state_nxt_s == IS_DONE);
      busy_r <= busy_nxt_s;
      if (accept_s && !long_s) begin
        result_r    <= unary_res_s;
        result_hi_r <= {WIDTH{1'b0}};
        div0_r      <= 1'b0;
      end else if (state_r == IS_FIX) begin
        result_r    <= fix_res_s;
        result_hi_r <= fix_hi_s;
        div0_r      <= fix_div0_s;
      end
    end
  end

  assign bus.done_o      = done_r;
  assign bus.busy_o      = busy_r;
  assign bus.result_o    = result_r;
  assign bus.result_hi_o = result_hi_r;
  assign bus.div0_o      = div0_r;

endmodule
